// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: note codes, ROM entry layout, FSM states.
package melody_pkg;

    localparam logic [1:0] NOTE_REST = 2'd0;
    localparam logic [1:0] NOTE_DO   = 2'd1;
    localparam logic [1:0] NOTE_RE   = 2'd2;
    localparam logic [1:0] NOTE_MI   = 2'd3;

    localparam logic [2:0] END_DUR = 3'd0;

    typedef struct packed {
        logic [1:0] note;
        logic [2:0] dur;
    } entry_t;

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StGap,
        StPause,
        StDone
    } state_e;

endpackage

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between the board top and the melody sequencer.
interface melody_sequencer_if #(
    parameter int unsigned ADDR_W = 4
) ();
    logic              start;
    logic              stop;
    logic [1:0]        key_note;
    logic [1:0]        note_address;
    logic              note_enable;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] song_idx;

    modport master (
        output start, stop, key_note,
        input  note_address, note_enable, busy, done, song_idx
    );

    modport slave (
        input  start, stop, key_note,
        output note_address, note_enable, busy, done, song_idx
    );
endinterface

// File: rtl/melody_rom.sv
// Combinational song ROM: address -> {note, dur}; unused addresses hold the end marker.
module melody_rom
    import melody_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] addr_i,
    output entry_t            entry_o
);
    always_comb begin
        entry_o = '{note: NOTE_REST, dur: END_DUR};
        case (addr_i)
            ADDR_W'(0): entry_o = '{note: NOTE_DO,   dur: 3'd2};
            ADDR_W'(1): entry_o = '{note: NOTE_RE,   dur: 3'd1};
            ADDR_W'(2): entry_o = '{note: NOTE_MI,   dur: 3'd2};
            ADDR_W'(3): entry_o = '{note: NOTE_REST, dur: 3'd1};
            ADDR_W'(4): entry_o = '{note: NOTE_DO,   dur: 3'd1};
            default:    entry_o = '{note: NOTE_REST, dur: END_DUR};
        endcase
    end
endmodule

// File: rtl/melody_sequencer.sv
// Steps through the song ROM driving the tone generator; manual keys override and pause playback.
// Define LOOP_EN to wrap back to entry 0 at song end instead of returning to idle.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned BEAT_HZ    = 8,
    parameter int unsigned GAP_CYCLES = 250000,
    parameter int unsigned SONG_LEN   = 16
) (
    input logic               clk,
    input logic               resetn,
    melody_sequencer_if.slave seq_if
);
    localparam int unsigned DIV     = CLK_HZ / BEAT_HZ;
    localparam int unsigned ADDR_W  = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int unsigned PRESC_W = $clog2(DIV);
    localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
    localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(SONG_LEN - 1);

    state_e              state_q, state_d, resume_q, resume_d, st_eff;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [2:0]          beat_q, beat_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [1:0]          note_q, note_d;
    logic [1:0]          addr_q, addr_d;
    logic                en_q, en_d, busy_q, busy_d, done_q, done_d;
    logic                kill, wrap;
    logic [1:0]          key;
    entry_t              first_entry, next_entry;

    assign key = seq_if.key_note;

    melody_rom #(.ADDR_W(ADDR_W)) u_rom_first (
        .addr_i  ('0),
        .entry_o (first_entry)
    );

    melody_rom #(.ADDR_W(ADDR_W)) u_rom_next (
        .addr_i  (idx_q + ADDR_W'(1)),
        .entry_o (next_entry)
    );

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        idx_d    = idx_q;
        presc_d  = presc_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        note_d   = note_q;
        kill     = 1'b0;
        wrap     = 1'b0;
        // Releasing the key resumes and takes the saved state's step in the same cycle,
        // so the paused entry keeps its exact sounding length.
        st_eff   = (state_q == StPause && key == NOTE_REST) ? resume_q : state_q;

        if (seq_if.stop && state_q != StIdle) begin
            state_d = StIdle;
            kill    = 1'b1;
        end else begin
            unique case (st_eff)
                StIdle: begin
                    if (seq_if.start && !seq_if.stop) begin
                        idx_d   = '0;
                        presc_d = '0;
                        beat_d  = first_entry.dur;
                        note_d  = first_entry.note;
                        state_d = (first_entry.dur == END_DUR) ? StDone : StPlay;
                    end
                end
                StPlay: begin
                    if (key != NOTE_REST) begin
                        state_d  = StPause;
                        resume_d = StPlay;
                    end else begin
                        state_d = StPlay;
                        if (presc_q == PRESC_LAST) begin
                            presc_d = '0;
                            if (beat_q == 3'd1) begin
                                state_d = StGap;
                                gap_d   = GAP_LOAD;
                            end else begin
                                beat_d = beat_q - 3'd1;
                            end
                        end else begin
                            presc_d = presc_q + PRESC_W'(1);
                        end
                    end
                end
                StGap: begin
                    if (key != NOTE_REST) begin
                        state_d  = StPause;
                        resume_d = StGap;
                    end else begin
                        state_d = StGap;
                        if (gap_q == '0) begin
                            if (next_entry.dur == END_DUR || idx_q == LAST_IDX) begin
`ifdef LOOP_EN
                                if (first_entry.dur != END_DUR) begin
                                    state_d = StPlay;
                                    idx_d   = '0;
                                    presc_d = '0;
                                    beat_d  = first_entry.dur;
                                    note_d  = first_entry.note;
                                    wrap    = 1'b1;
                                end else begin
                                    state_d = StDone;
                                end
`else
                                state_d = StDone;
`endif
                            end else begin
                                state_d = StPlay;
                                idx_d   = idx_q + ADDR_W'(1);
                                presc_d = '0;
                                beat_d  = next_entry.dur;
                                note_d  = next_entry.note;
                            end
                        end else begin
                            gap_d = gap_q - GAP_W'(1);
                        end
                    end
                end
                StPause: state_d = StPause;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end

        busy_d = state_d inside {StPlay, StGap, StPause};
        done_d = (state_d == StDone) || wrap;
        if (kill) begin
            addr_d = NOTE_REST;
        end else if (key != NOTE_REST) begin
            addr_d = key;
        end else if (state_d == StPlay) begin
            addr_d = note_d;
        end else begin
            addr_d = NOTE_REST;
        end
        en_d = (addr_d != NOTE_REST);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            resume_q <= StPlay;
            idx_q    <= '0;
            presc_q  <= '0;
            beat_q   <= '0;
            gap_q    <= '0;
            note_q   <= NOTE_REST;
            addr_q   <= NOTE_REST;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            idx_q    <= idx_d;
            presc_q  <= presc_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            note_q   <= note_d;
            addr_q   <= addr_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign seq_if.note_address = addr_q;
    assign seq_if.note_enable  = en_q;
    assign seq_if.busy         = busy_q;
    assign seq_if.done         = done_q;
    assign seq_if.song_idx     = idx_q;

endmodule
